// File: rtl/sramx_multi_pkg.sv
// Shared types and constants for the multi-port SRAM merger.
package sramx_multi_pkg;
    localparam int MAX_CH  = 8;
    localparam int CH_ID_W = 3;

    // Sized for the largest supported channel count so every instance shares one tag type.
    typedef logic [CH_ID_W-1:0] ch_id_t;

    typedef struct packed {
        logic   valid;
        ch_id_t ch_id;
    } resp_tag_t;

    localparam logic [31:0] KSEG01_MASK = 32'h1FFF_FFFF;
    localparam logic [1:0]  KSEG01_TAG  = 2'b10;

    function automatic logic [31:0] kseg_xlate(input logic [31:0] va);
        return (va[31:30] == KSEG01_TAG) ? (va & KSEG01_MASK) : va;
    endfunction
endpackage

// File: rtl/sramx_multi_port_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts at rr_ptr.
module rr_arbiter
    import sramx_multi_pkg::*;
#(
    parameter  int N   = 2,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);
    logic [IDW-1:0] rr_ptr;
    logic [IDW:0]   idx;
    logic           any_gnt;

    // Extra bit on idx lets ptr+i exceed N-1 before the modulo fold.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
            if (!any_gnt && !reset && req[idx[IDW-1:0]]) begin
                any_gnt                = 1'b1;
                gnt[idx[IDW-1:0]]      = 1'b1;
                gnt_id                 = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (any_gnt)
            rr_ptr <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
    end
endmodule

// File: rtl/sramx_multi_port.sv
// Merges NUM_CH SRAM-style requesters onto one shared SRAM port with
// round-robin arbitration and a fixed-latency, in-order response path.
module sramx_multi_port
    import sramx_multi_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int TRANSLATE = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 ch_valid,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]     ch_addr,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0]   ch_strobe,
    input  logic [NUM_CH-1:0][DATA_W-1:0]     ch_wdata,
    output logic [NUM_CH-1:0]                 ch_addr_ok,
    output logic [NUM_CH-1:0]                 ch_data_ok,
    output logic [DATA_W-1:0]                 ch_rdata,
    output logic                              sram_en,
    output logic [DATA_W/8-1:0]               sram_wen,
    output logic [ADDR_W-1:0]                 sram_addr,
    output logic [DATA_W-1:0]                 sram_wdata,
    input  logic [DATA_W-1:0]                 sram_rdata
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] gnt;
    logic [IDW-1:0]    gnt_id;
    logic              any_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] phys_addr;
    logic [STRB_W-1:0] sel_strb;
    logic [DATA_W-1:0] sel_wdata;
    resp_tag_t         tag_p [RD_LAT];
    resp_tag_t         tag_out;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (ch_valid),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign any_gnt    = |gnt;
    assign ch_addr_ok = gnt;

    // One-hot AND-OR mux; with no grant everything collapses to zero.
    always_comb begin
        sel_addr  = '0;
        sel_strb  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_addr  = sel_addr  | ch_addr[i];
                sel_strb  = sel_strb  | ch_strobe[i];
                sel_wdata = sel_wdata | ch_wdata[i];
            end
        end
    end

    if (TRANSLATE != 0 && ADDR_W == 32) begin : g_xlate
        assign phys_addr = kseg_xlate(sel_addr);
    end else begin : g_pass
        assign phys_addr = sel_addr;
    end

    // Stage p0: SRAM request issued in the grant cycle.
    assign sram_en    = any_gnt;
    assign sram_wen   = sel_strb;
    assign sram_addr  = phys_addr;
    assign sram_wdata = sel_wdata;

    // Stages p1..pRD_LAT: response tags march alongside the SRAM read latency.
    always_ff @(posedge clk) begin
        tag_p[0].ch_id <= ch_id_t'(gnt_id);
        tag_p[0].valid <= reset ? 1'b0 : any_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_p[i].ch_id <= tag_p[i-1].ch_id;
            tag_p[i].valid <= reset ? 1'b0 : tag_p[i-1].valid;
        end
    end

    assign tag_out = tag_p[RD_LAT-1];

    always_comb begin
        ch_data_ok = '0;
        if (!reset && tag_out.valid) begin
            for (int i = 0; i < NUM_CH; i++)
                ch_data_ok[i] = (tag_out.ch_id == ch_id_t'(i));
        end
    end

    assign ch_rdata = reset ? '0 : sram_rdata;
endmodule
